eight_bit_full_adder: RTL and testbench

- Registered 8-bit binary adder with carry-in and carry-out. Computes A + B + Cin and presents the result one clock later.
- Combinational core is a ripple-carry chain of single-bit full adders, followed by an output register stage.
- Used as a leaf arithmetic primitive in datapaths. Its Cout can feed the Cin of another instance to build wider adders.

---
 rtl/adder_pkg.sv | 9 +
 rtl/full_adder_bit.sv | 13 +
 rtl/eight_bit_full_adder.sv | 49 ++++
 tb/tb_eight_bit_full_adder.sv | 127 ++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// Shared definitions for the registered ripple-carry adder.
// Holds the default operand width and the operand type used by callers.
package adder_pkg;

  localparam int ADDER_WIDTH = 8;

  typedef logic [ADDER_WIDTH-1:0] operand_t;

endpackage : adder_pkg

// File: rtl/full_adder_bit.sv
// Single-bit full adder: one link of the ripple-carry chain.
module full_adder_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (a & cin) | (b & cin);

endmodule : full_adder_bit

// File: rtl/eight_bit_full_adder.sv
// Registered WIDTH-bit adder: ripple chain of full_adder_bit cells feeding one output register stage.
// Handshake: in_valid qualifies A/B/Cin on an edge; out_valid pulses for exactly one cycle per captured result (no backpressure).
module eight_bit_full_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             out_valid
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = Cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder_bit u_bit (
      .a    (A[i]),
      .b    (B[i]),
      .cin  (c[i]),
      .s    (s[i]),
      .cout (c[i+1])
    );
  end

  // Result registers only load on in_valid, so idle-cycle inputs never reach the outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      Sum       <= '0;
      Cout      <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) begin
        Sum  <= s;
        Cout <= c[WIDTH];
      end
    end
  end

endmodule : eight_bit_full_adder

// File: tb/tb_eight_bit_full_adder.sv
// Scoreboard bench for eight_bit_full_adder: directed cases plus a random sweep against an arithmetic reference.
module tb_eight_bit_full_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         cin = 1'b0;
  logic [W-1:0] sum;
  logic         cout;
  logic         out_valid;

  logic [W:0]   exp_q[$];
  logic [W:0]   held = '0;
  int           checks = 0;
  int           fails = 0;
  bit           stim_done = 1'b0;

  eight_bit_full_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .A         (a),
    .B         (b),
    .Cin       (cin),
    .Sum       (sum),
    .Cout      (cout),
    .out_valid (out_valid)
  );

  // clock / reset
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: inputs change on the falling edge; the expected response is queued as issued
  task automatic drive(input logic r, input logic v, input logic [W-1:0] da,
                       input logic [W-1:0] db, input logic dc);
    @(negedge clk);
    rst      = r;
    in_valid = v;
    a        = da;
    b        = db;
    cin      = dc;
    if (r) exp_q.delete();
    else if (v) exp_q.push_back({1'b0, da} + {1'b0, db} + {{W{1'b0}}, dc});
  endtask

  // monitor / scoreboard
  initial begin
    logic       rst_s;
    logic [W:0] e;
    forever begin
      @(posedge clk);
      rst_s = rst;
      #2;
      if (rst_s) begin
        check("rst_sum", 32'(sum), 32'h0);
        check("rst_cout", 32'(cout), 32'h0);
        check("rst_out_valid", 32'(out_valid), 32'h0);
        held = '0;
      end else if (!stim_done) begin
        check("out_valid", 32'(out_valid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          held = e;
        end
        check("sum", 32'(sum), 32'(held[W-1:0]));
        check("cout", 32'(cout), 32'(held[W]));
      end
    end
  end

  initial begin
    logic [W-1:0] ta [11];
    logic [W-1:0] tb_ [11];
    logic         tc [11];
    ta  = '{8'h01, 8'h01, 8'hF0, 8'hFF, 8'hAA, 8'hCC, 8'h00, 8'h80, 8'h0F, 8'hFF, 8'h00};
    tb_ = '{8'h00, 8'h01, 8'h0F, 8'h01, 8'h55, 8'h33, 8'hFF, 8'h80, 8'h0F, 8'hFF, 8'h00};
    tc  = '{1'b0,  1'b0,  1'b0,  1'b0,  1'b1,  1'b1,  1'b1,  1'b0,  1'b1,  1'b1,  1'b0};

    // reset held for two cycles with a valid all-ones operation presented
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);
    drive(1'b1, 1'b1, 8'hFF, 8'hFF, 1'b1);

    // directed back-to-back: basic, carry propagation, MSB/mid carries, zero
    for (int i = 0; i < 11; i++) drive(1'b0, 1'b1, ta[i], tb_[i], tc[i]);

    // hold: capture 0x12+0x34 then go idle with all-ones on the inputs
    drive(1'b0, 1'b1, 8'h12, 8'h34, 1'b0);
    drive(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    drive(1'b0, 1'b0, 8'hFF, 8'hFF, 1'b1);
    @(posedge clk);
    #3;
    check("hold_sum_46", 32'(sum), 32'h46);
    check("hold_cout_0", 32'(cout), 32'h0);

    // mid-stream reset discards the in-flight result
    drive(1'b0, 1'b1, 8'h77, 8'h11, 1'b0);
    drive(1'b1, 1'b1, 8'h01, 8'h02, 1'b0);

    // random sweep
    for (int n = 0; n < 10000; n++) begin
      drive(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) != 0),
            W'($urandom), W'($urandom), 1'($urandom));
    end

    drive(1'b0, 1'b0, '0, '0, 1'b0);
    drive(1'b0, 1'b0, '0, '0, 1'b0);
    @(posedge clk);
    #3;
    check("queue_drained", 32'(exp_q.size()), 32'h0);
    stim_done = 1'b1;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule : tb_eight_bit_full_adder
